udma_tcdm_arbiter: RTL and testbench

Round-robin arbiter that shares one L2 TCDM master port between `N_PORTS` uDMA-side TCDM requesters, for example the read-only and write-only L2 channels of `pulp_io`. It forwards the granted request with zero added latency. It records the requester ID of every granted transaction in an in-order ID FIFO and routes each `rvalid`/`rdata` response back to the requester that issued it. It sits between the uDMA L2 ports and the L2 interconnect or TCDM model.

---
 rtl/udma_tcdm_arb_pkg.sv | 34 +++
 rtl/tcdm_arb_id_fifo.sv | 73 +++++++
 rtl/udma_tcdm_arbiter.sv | 174 +++++++++++++++++
 tb/tb_udma_tcdm_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_tcdm_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_tcdm_arb_pkg : shared types and helpers for udma_tcdm_arbiter    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package udma_tcdm_arb_pkg;

   localparam int unsigned TCDM_ADDR_W = 32;
   localparam int unsigned TCDM_DATA_W = 32;

   typedef struct packed {
      logic [TCDM_ADDR_W-1:0]   addr;
      logic                     wen;
      logic [TCDM_DATA_W/8-1:0] be;
      logic [TCDM_DATA_W-1:0]   wdata;
   } tcdm_req_t;

   typedef struct packed {
      logic                   rvalid;
      logic [TCDM_DATA_W-1:0] rdata;
   } tcdm_rsp_t;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Requester-ID width; never narrower than one bit
   function automatic int unsigned id_w(input int unsigned n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_arb_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tcdm_arb_id_fifo : in-order requester-ID FIFO, same-cycle push/pop    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tcdm_arb_id_fifo #(
   parameter int unsigned ID_W  = 1,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [ID_W-1:0]  push_id_i,
   input  logic             pop_i,
   output logic [ID_W-1:0]  head_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [ID_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_push = push_i && (cnt_q != CNT_W'(DEPTH));
      do_pop  = pop_i && (cnt_q != '0);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_id_i;
         wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
         rd_d = ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/udma_tcdm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_tcdm_arbiter : round-robin N:1 TCDM arbiter with in-order        |
// | response routing. Optional counters with TCDM_ARB_PERF_EN.            |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module udma_tcdm_arbiter
   import udma_tcdm_arb_pkg::*;
#(
   parameter int unsigned N_PORTS         = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                  sys_clk_i,
   input  logic                                  sys_rst_i,
   input  logic [N_PORTS-1:0]                    req_i,
   output logic [N_PORTS-1:0]                    gnt_o,
   input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
   input  logic [N_PORTS-1:0]                    wen_i,
   input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
   input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
   output logic [N_PORTS-1:0]                    rvalid_o,
   output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
   output logic                                  tcdm_req_o,
   output logic [ADDR_WIDTH-1:0]                 tcdm_addr_o,
   output logic                                  tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0]               tcdm_be_o,
   output logic [DATA_WIDTH-1:0]                 tcdm_wdata_o,
   input  logic                                  tcdm_gnt_i,
   input  logic                                  tcdm_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                 tcdm_rdata_i,
`ifdef TCDM_ARB_PERF_EN
   output logic [N_PORTS-1:0][31:0]              perf_gnt_cnt_o,
   output logic [N_PORTS-1:0][31:0]              perf_stall_cnt_o,
`endif
   output logic                                  resp_err_o
);

   localparam int unsigned ID_W  = id_w(N_PORTS);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  lock_id_q, lock_id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  rr_sel, sel, fifo_head;
   logic             rr_found, handshake, fifo_full, fifo_empty, rsp_pop;
   logic [CNT_W-1:0] fifo_cnt;
   int               idx;

   // Full is judged on the registered count only, so rvalid never reaches req
   assign fifo_full  = (fifo_cnt == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (fifo_cnt == '0);

   // Lowest offset from rr_ptr wins; scan downwards so it is assigned last
   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      idx      = 0;
      for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % int'(N_PORTS);
         if (req_i[idx]) begin
            rr_sel   = ID_W'(idx);
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel        = rr_sel;
      tcdm_req_o = rr_found & ~fifo_full;
      state_d    = state_q;
      lock_id_d  = lock_id_q;
      if (state_q == ARB_LOCKED) begin
         sel        = lock_id_q;
         tcdm_req_o = req_i[lock_id_q] & ~fifo_full;
      end
      handshake = tcdm_req_o & tcdm_gnt_i;
      case (state_q)
         ARB_IDLE: begin
            if (tcdm_req_o && !tcdm_gnt_i) begin
               state_d   = ARB_LOCKED;
               lock_id_d = sel;
            end
         end
         ARB_LOCKED: begin
            if (!req_i[lock_id_q] || handshake) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      rr_ptr_d = rr_ptr_q;
      if (handshake) begin
         rr_ptr_d = ID_W'((int'(sel) + 1) % int'(N_PORTS));
      end
      gnt_o      = '0;
      gnt_o[sel] = handshake;
   end

   assign tcdm_addr_o  = addr_i[sel];
   assign tcdm_wen_o   = wen_i[sel];
   assign tcdm_be_o    = be_i[sel];
   assign tcdm_wdata_o = wdata_i[sel];

   always_comb begin
      rsp_pop             = tcdm_rvalid_i & ~fifo_empty;
      resp_err_o          = tcdm_rvalid_i & fifo_empty;
      rvalid_o            = '0;
      rvalid_o[fifo_head] = rsp_pop;
   end

   for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_rdata
      assign rdata_o[i] = tcdm_rdata_i;
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q   <= ARB_IDLE;
         lock_id_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   tcdm_arb_id_fifo #(
      .ID_W  (ID_W),
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_id_fifo (
      .clk       (sys_clk_i),
      .rst       (sys_rst_i),
      .push_i    (handshake),
      .push_id_i (sel),
      .pop_i     (rsp_pop),
      .head_o    (fifo_head),
      .count_o   (fifo_cnt)
   );

`ifdef TCDM_ARB_PERF_EN
   for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_perf
      logic [31:0] gnt_cnt_q, gnt_cnt_d, stall_cnt_q, stall_cnt_d;

      always_comb begin
         gnt_cnt_d   = gnt_cnt_q;
         stall_cnt_d = stall_cnt_q;
         if (gnt_o[i] && (gnt_cnt_q != '1)) begin
            gnt_cnt_d = gnt_cnt_q + 32'd1;
         end
         if (req_i[i] && !gnt_o[i] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end

      always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
         if (sys_rst_i) begin
            gnt_cnt_q   <= '0;
            stall_cnt_q <= '0;
         end else begin
            gnt_cnt_q   <= gnt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
         end
      end

      assign perf_gnt_cnt_o[i]   = gnt_cnt_q;
      assign perf_stall_cnt_o[i] = stall_cnt_q;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_udma_tcdm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_udma_tcdm_arbiter : directed vector table plus corner sequences    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_udma_tcdm_arbiter;
   import udma_tcdm_arb_pkg::*;

   logic             clk;
   logic             sys_rst_i;
   logic [1:0]       req_i, gnt_o, wen_i, rvalid_o;
   logic [1:0][31:0] addr_i, wdata_i, rdata_o;
   logic [1:0][3:0]  be_i;
   logic             tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_rvalid_i, resp_err_o;
   logic [31:0]      tcdm_addr_o, tcdm_wdata_o, tcdm_rdata_i;
   logic [3:0]       tcdm_be_o;
`ifdef TCDM_ARB_PERF_EN
   logic [1:0][31:0] perf_gnt_cnt_o, perf_stall_cnt_o;
`endif

   tcdm_req_t ports [2];
   int        checks = 0;
   int        errors = 0;

   typedef struct {
      logic [1:0] req;
      logic       gnt;
      logic       rv;
      logic       ereq;
      logic       esel;
      logic [1:0] egnt;
      logic [1:0] erv;
      logic       eerr;
   } vec_t;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          t;
   } txn_t;

   udma_tcdm_arbiter #(
      .N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
   ) dut (
      .sys_clk_i     (clk),
      .sys_rst_i     (sys_rst_i),
      .req_i         (req_i),
      .gnt_o         (gnt_o),
      .addr_i        (addr_i),
      .wen_i         (wen_i),
      .be_i          (be_i),
      .wdata_i       (wdata_i),
      .rvalid_o      (rvalid_o),
      .rdata_o       (rdata_o),
      .tcdm_req_o    (tcdm_req_o),
      .tcdm_addr_o   (tcdm_addr_o),
      .tcdm_wen_o    (tcdm_wen_o),
      .tcdm_be_o     (tcdm_be_o),
      .tcdm_wdata_o  (tcdm_wdata_o),
      .tcdm_gnt_i    (tcdm_gnt_i),
      .tcdm_rvalid_i (tcdm_rvalid_i),
      .tcdm_rdata_i  (tcdm_rdata_i),
`ifdef TCDM_ARB_PERF_EN
      .perf_gnt_cnt_o   (perf_gnt_cnt_o),
      .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
      .resp_err_o    (resp_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         addr_i[p]  = ports[p].addr;
         wen_i[p]   = ports[p].wen;
         be_i[p]    = ports[p].be;
         wdata_i[p] = ports[p].wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive at posedge+1, sample 3 ns later, advance to next posedge+1
   task automatic cyc(input string nm, input logic [1:0] r, input logic g, input logic rv,
                      input logic ereq, input logic esel, input logic [1:0] egnt,
                      input logic [1:0] erv, input logic eerr);
      logic [31:0] rd;
      rd            = 32'hD00D_0000 + 32'(checks);
      req_i         = r;
      tcdm_gnt_i    = g;
      tcdm_rvalid_i = rv;
      tcdm_rdata_i  = rd;
      #3;
      chk({nm, "/tcdm_req"}, 32'(tcdm_req_o), 32'(ereq));
      chk({nm, "/gnt"}, 32'(gnt_o), 32'(egnt));
      chk({nm, "/rvalid"}, 32'(rvalid_o), 32'(erv));
      chk({nm, "/resp_err"}, 32'(resp_err_o), 32'(eerr));
      if (ereq) begin
         chk({nm, "/addr"}, tcdm_addr_o, ports[esel].addr);
         chk({nm, "/wen"}, 32'(tcdm_wen_o), 32'(ports[esel].wen));
         chk({nm, "/be"}, 32'(tcdm_be_o), 32'(ports[esel].be));
         chk({nm, "/wdata"}, tcdm_wdata_o, ports[esel].wdata);
      end
      if (rv) begin
         chk({nm, "/rdata0"}, rdata_o[0], rd);
         chk({nm, "/rdata1"}, rdata_o[1], rd);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [16];
   txn_t q [$];

   initial begin
      logic [1:0] pend;
      int         cyc_n, done, last_t, g, t;

      tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
      tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0};
      tbl[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0};
      tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0};
      tbl[5]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      tbl[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[8]  = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
      tbl[9]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
      tbl[10] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[11] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
      tbl[12] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
      tbl[13] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[14] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
      tbl[15] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};

      ports[0]      = '{addr: 32'h0000_1000, wen: 1'b1, be: 4'hF, wdata: 32'h0000_0000};
      ports[1]      = '{addr: 32'h0000_2000, wen: 1'b0, be: 4'h3, wdata: 32'hCAFE_0001};
      sys_rst_i     = 1'b1;
      req_i         = 2'b00;
      tcdm_gnt_i    = 1'b0;
      tcdm_rvalid_i = 1'b0;
      tcdm_rdata_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset/gnt", 32'(gnt_o), 32'h0);
      chk("in_reset/rvalid", 32'(rvalid_o), 32'h0);
      chk("in_reset/tcdm_req", 32'(tcdm_req_o), 32'h0);
      sys_rst_i = 1'b0;

      // Round-robin, spurious response, outstanding limit
      for (int i = 0; i < 16; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].ereq,
             tbl[i].esel, tbl[i].egnt, tbl[i].erv, tbl[i].eerr);
      end

      // Lock stability: rr points at port 1, but the stalled port 0 request holds
      cyc("lock_a", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
      cyc("lock_b", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0);
      cyc("lock_c", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      cyc("lock_d", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      cyc("lock_e", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
      cyc("lock_f", 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0);
      // Locked requester withdraws: one idle cycle, then re-arbitration
      cyc("drop_a", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0);
      cyc("drop_b", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      cyc("drop_c", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
      cyc("drop_d", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);

      // Reset with two outstanding and rr_ptr at 1
      cyc("rst_a", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
      cyc("rst_b", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
      req_i      = 2'b00;
      tcdm_gnt_i = 1'b0;
      sys_rst_i  = 1'b1;
      #3;
      chk("rst_mid/tcdm_req", 32'(tcdm_req_o), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      sys_rst_i = 1'b0;
      cyc("rst_c", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      cyc("rst_d", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      cyc("rst_e", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
      cyc("rst_f", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);

      // Random stalls and 1-3 cycle in-order response latency
      pend   = 2'b00;
      cyc_n  = 0;
      done   = 0;
      last_t = 0;
      while (done < 1000 && cyc_n < 20000) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(1, 0) == 1)) begin
               pend[p]        = 1'b1;
               ports[p].addr  = $urandom & 32'hFFFF_FFFC;
               ports[p].wen   = 1'($urandom_range(1, 0));
               ports[p].wdata = $urandom;
            end
         end
         req_i         = pend;
         tcdm_gnt_i    = 1'($urandom_range(1, 0));
         tcdm_rvalid_i = (q.size() > 0) && (q[0].t == cyc_n);
         tcdm_rdata_i  = tcdm_rvalid_i ? q[0].data : $urandom;
         #3;
         if (tcdm_rvalid_i) begin
            chk("rand_route", 32'(rvalid_o), 32'(1) << q[0].port);
            chk("rand_rdata", rdata_o[q[0].port], q[0].data);
            void'(q.pop_front());
            done++;
         end else begin
            chk("rand_no_rvalid", 32'(rvalid_o), 32'h0);
         end
         if (tcdm_req_o && tcdm_gnt_i) begin
            g = gnt_o[1] ? 1 : 0;
            chk("rand_gnt_onehot", 32'($countones(gnt_o)), 32'h1);
            chk("rand_gnt_req", 32'(req_i[g]), 32'h1);
            chk("rand_addr", tcdm_addr_o, ports[g].addr);
            t      = cyc_n + int'($urandom_range(3, 1));
            t      = (t > last_t) ? t : last_t + 1;
            last_t = t;
            q.push_back('{g, ports[g].addr ^ 32'hA5A5_5A5A, t});
            pend[g] = 1'b0;
         end else begin
            chk("rand_gnt_zero", 32'(gnt_o), 32'h0);
         end
         chk("rand_resp_err", 32'(resp_err_o), 32'h0);
         @(posedge clk);
         #1;
         cyc_n++;
      end
      chk("rand_completed", 32'(done), 32'd1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
